// File: rtl/mastermind_board_engine.sv
// Mastermind/Wordle board engine: holds the colour board, edits the active
// row through a wrapping cursor, scores submitted rows with a multi-cycle
// scorer (exact matches, then per-colour histogram overlap) and tracks win/lose.
module mastermind_board_engine #(
    parameter int NUM_PEGS   = 4,
    parameter int COLOR_W    = 3,
    parameter int NUM_COLORS = 6,
    parameter int NUM_ROWS   = 6,
    localparam int P_W   = NUM_PEGS * COLOR_W,
    localparam int IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1,
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int CNT_W = $clog2(NUM_PEGS + 1)
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      start,
    input  logic [P_W-1:0]            answer,
    input  logic [COLOR_W-1:0]        color_in,
    input  logic                      set_color,
    input  logic                      cur_left,
    input  logic                      cur_right,
    input  logic                      submit,
    output logic [NUM_ROWS*P_W-1:0]   board_flat,
    output logic [NUM_ROWS*2*CNT_W-1:0] score_flat,
    output logic [ROW_W-1:0]          row_idx,
    output logic [IDX_W-1:0]          cursor,
    output logic                      score_valid,
    output logic                      q_Start,
    output logic                      q_Input,
    output logic                      q_Score,
    output logic                      q_DoneC,
    output logic                      q_DoneNC
);

    // Scorer sequencing: steps 0..NUM_PEGS-1 compare pegs, the next NUM_COLORS
    // steps accumulate histogram overlap, then one step writes the score and
    // one more step chooses the next state.
    localparam int STEP_W = $clog2(NUM_PEGS + NUM_COLORS + 2);
    localparam logic [STEP_W-1:0]  STEP_B0    = STEP_W'(NUM_PEGS);
    localparam logic [STEP_W-1:0]  STEP_WRITE = STEP_W'(NUM_PEGS + NUM_COLORS);
    localparam logic [IDX_W-1:0]   PEG_LAST   = IDX_W'(NUM_PEGS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS - 1);
    localparam logic [COLOR_W-1:0] MAX_COLOR  = COLOR_W'(NUM_COLORS);
    localparam logic [CNT_W-1:0]   ALL_BLACK  = CNT_W'(NUM_PEGS);

    // One-hot encoding so each state flag is a flop bit directly.
    typedef enum logic [4:0] {
        S_START   = 5'b00001,
        S_INPUT   = 5'b00010,
        S_SCORE   = 5'b00100,
        S_DONE_C  = 5'b01000,
        S_DONE_NC = 5'b10000
    } state_t;

    state_t state_q, state_d;
    logic [NUM_ROWS-1:0][NUM_PEGS-1:0][COLOR_W-1:0] board_q, board_d;
    logic [NUM_ROWS-1:0][1:0][CNT_W-1:0]            score_q, score_d;
    logic [NUM_PEGS-1:0][COLOR_W-1:0]               answer_q, answer_d;
    logic [(1<<COLOR_W)-1:0][CNT_W-1:0]             hist_g_q, hist_g_d;
    logic [(1<<COLOR_W)-1:0][CNT_W-1:0]             hist_a_q, hist_a_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic [IDX_W-1:0]  cursor_q, cursor_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  black_q, black_d;
    logic [CNT_W-1:0]  sum_q, sum_d;
    logic              score_valid_q, score_valid_d;

    logic [NUM_PEGS-1:0] peg_full;
    logic [IDX_W-1:0]    peg_sel;
    logic [COLOR_W-1:0]  guess_peg, ans_peg, color_sel, write_color;
    logic [CNT_W-1:0]    hist_g_sel, hist_a_sel, min_sel;

    // A row may be submitted only when every peg holds a colour.
    for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_full
        assign peg_full[gi] = |board_q[row_idx_q][gi];
    end

    assign peg_sel     = step_q[IDX_W-1:0];
    assign guess_peg   = board_q[row_idx_q][peg_sel];
    assign ans_peg     = answer_q[peg_sel];
    assign color_sel   = COLOR_W'(step_q - STEP_B0 + STEP_W'(1));
    assign hist_g_sel  = hist_g_q[color_sel];
    assign hist_a_sel  = hist_a_q[color_sel];
    assign min_sel     = (hist_g_sel < hist_a_sel) ? hist_g_sel : hist_a_sel;
    assign write_color = (color_in > MAX_COLOR) ? '0 : color_in;

    // Next-state logic for the game FSM, board editing and the scorer.
    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        score_d       = score_q;
        answer_d      = answer_q;
        row_idx_d     = row_idx_q;
        cursor_d      = cursor_q;
        step_d        = step_q;
        black_d       = black_q;
        sum_d         = sum_q;
        hist_g_d      = hist_g_q;
        hist_a_d      = hist_a_q;
        score_valid_d = 1'b0;
        if (start && (state_q != S_SCORE)) begin
            state_d   = S_INPUT;
            answer_d  = answer;
            board_d   = '0;
            score_d   = '0;
            row_idx_d = '0;
            cursor_d  = '0;
        end else begin
            case (state_q)
                S_INPUT: begin
                    if (submit && (&peg_full)) begin
                        state_d  = S_SCORE;
                        step_d   = '0;
                        black_d  = '0;
                        sum_d    = '0;
                        hist_g_d = '0;
                        hist_a_d = '0;
                    end else begin
                        // The write uses the cursor as it was before any move.
                        if (set_color)
                            board_d[row_idx_q][cursor_q] = write_color;
                        if (cur_left && !cur_right)
                            cursor_d = (cursor_q == '0) ? PEG_LAST : cursor_q - IDX_W'(1);
                        else if (cur_right && !cur_left)
                            cursor_d = (cursor_q == PEG_LAST) ? '0 : cursor_q + IDX_W'(1);
                    end
                end
                S_SCORE: begin
                    step_d = step_q + STEP_W'(1);
                    if (step_q < STEP_B0) begin
                        if (guess_peg == ans_peg)
                            black_d = black_q + CNT_W'(1);
                        hist_g_d[guess_peg] = hist_g_q[guess_peg] + CNT_W'(1);
                        hist_a_d[ans_peg]   = hist_a_q[ans_peg] + CNT_W'(1);
                    end else if (step_q < STEP_WRITE) begin
                        sum_d = sum_q + min_sel;
                    end else if (step_q == STEP_WRITE) begin
                        score_d[row_idx_q] = {sum_q - black_q, black_q};
                        score_valid_d      = 1'b1;
                    end else begin
                        if (black_q == ALL_BLACK) begin
                            state_d = S_DONE_C;
                        end else if (row_idx_q == ROW_LAST) begin
                            state_d = S_DONE_NC;
                        end else begin
                            state_d   = S_INPUT;
                            row_idx_d = row_idx_q + ROW_W'(1);
                            cursor_d  = '0;
                        end
                    end
                end
                S_START, S_DONE_C, S_DONE_NC: ;
                default: state_d = S_START;
            endcase
        end
    end

    // All state and outputs are registered; reset aborts any scoring in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_START;
            board_q       <= '0;
            score_q       <= '0;
            answer_q      <= '0;
            row_idx_q     <= '0;
            cursor_q      <= '0;
            step_q        <= '0;
            black_q       <= '0;
            sum_q         <= '0;
            hist_g_q      <= '0;
            hist_a_q      <= '0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            score_q       <= score_d;
            answer_q      <= answer_d;
            row_idx_q     <= row_idx_d;
            cursor_q      <= cursor_d;
            step_q        <= step_d;
            black_q       <= black_d;
            sum_q         <= sum_d;
            hist_g_q      <= hist_g_d;
            hist_a_q      <= hist_a_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign board_flat  = board_q;
    assign score_flat  = score_q;
    assign row_idx     = row_idx_q;
    assign cursor      = cursor_q;
    assign score_valid = score_valid_q;
    assign q_Start     = state_q[0];
    assign q_Input     = state_q[1];
    assign q_Score     = state_q[2];
    assign q_DoneC     = state_q[3];
    assign q_DoneNC    = state_q[4];

endmodule
